rotary_paddle_decoder: RTL



---
 rtl/rotary_paddle_decoder.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/rotary_paddle_decoder.sv
// Rotary encoder receiver: sync + debounce of quadrature lines, detent decode,
// saturating paddle position committed on frame_tick. Define ROTARY_ACCEL_EN for fast-spin acceleration.

module rotary_paddle_deb #(
  parameter int DEB_LIMIT = 625,
  parameter int DEB_W     = 10
) (
  input  logic clk25,
  input  logic rst,
  input  logic raw,
  output logic deb
);
  logic             s1, s2;
  logic [DEB_W-1:0] cnt;

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      deb <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == deb) cnt <= '0;
      else if (cnt == DEB_W'(DEB_LIMIT - 1)) begin
        deb <= s2;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

module rotary_paddle_decoder #(
  parameter int DEB_LIMIT    = 625,
  parameter int DEB_W        = 10,
  parameter int POS_W        = 10,
  parameter int POS_MIN      = 0,
  parameter int POS_MAX      = 416,
  parameter int POS_INIT     = 208,
  parameter int STEP         = 4,
  parameter int ACCEL_WINDOW = 250000
) (
  input  logic             clk25,
  input  logic             rst,
  input  logic             rota,
  input  logic             rotb,
  input  logic             frame_tick,
  output logic [POS_W-1:0] paddle_y,
  output logic             step_cw,
  output logic             step_ccw,
  output logic             quad_err
);
  localparam logic [POS_W:0] PMIN = (POS_W+1)'(POS_MIN);
  localparam logic [POS_W:0] PMAX = (POS_W+1)'(POS_MAX);

  if (DEB_LIMIT < 1 || (DEB_LIMIT - 1) >= (2 ** DEB_W) || ACCEL_WINDOW < 1) begin : g_param_chk
    $error("rotary_paddle_decoder: bad DEB_LIMIT/DEB_W/ACCEL_WINDOW");
  end

  logic [1:0] raw, deb, prev;
  assign raw = {rota, rotb};

  for (genvar i = 0; i < 2; i++) begin : g_deb
    rotary_paddle_deb #(.DEB_LIMIT(DEB_LIMIT), .DEB_W(DEB_W)) u_deb (
      .clk25 (clk25),
      .rst   (rst),
      .raw   (raw[i]),
      .deb   (deb[i])
    );
  end

  // Gray-to-binary phase index: 00->0, 01->1, 11->2, 10->3 along the CW sequence
  function automatic logic [1:0] gidx(input logic [1:0] ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction

  logic signed [3:0] q, q_nxt, q_d;
  logic [1:0]        chg;
  logic              fwd, cw_c, ccw_c, err_c;

  always_comb begin
    chg   = deb ^ prev;
    fwd   = (gidx(deb) == gidx(prev) + 2'd1);
    q_nxt = q;
    q_d   = q;
    cw_c  = 1'b0;
    ccw_c = 1'b0;
    err_c = 1'b0;
    if (chg == 2'b11) begin
      err_c = 1'b1;
      q_d   = '0;
    end else if (chg != 2'b00) begin
      q_nxt = fwd ? q + 4'sd1 : q - 4'sd1;
      if (deb == 2'b00) begin
        cw_c  = (q_nxt == 4'sd4);
        ccw_c = (q_nxt == -4'sd4);
        q_d   = '0;
      end else q_d = q_nxt;
    end
  end

  logic [POS_W:0]   stp, up;
  logic [POS_W-1:0] pos_int, pos_nxt;

`ifdef ROTARY_ACCEL_EN
  localparam int AW = $clog2(ACCEL_WINDOW + 1);
  logic [AW-1:0] ivl;

  // Starts saturated so the first detent after reset is never accelerated
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst)                          ivl <= AW'(ACCEL_WINDOW);
    else if (cw_c || ccw_c)           ivl <= '0;
    else if (ivl != AW'(ACCEL_WINDOW)) ivl <= ivl + 1'b1;
  end

  assign stp = (ivl < AW'(ACCEL_WINDOW)) ? (POS_W+1)'(2 * STEP) : (POS_W+1)'(STEP);
`else
  assign stp = (POS_W+1)'(STEP);
`endif

  // Clamp in POS_W+1 bits so neither end can wrap
  always_comb begin
    up      = {1'b0, pos_int} + stp;
    pos_nxt = pos_int;
    if (cw_c) begin
      pos_nxt = (up > PMAX) ? PMAX[POS_W-1:0] : up[POS_W-1:0];
    end else if (ccw_c) begin
      if ({1'b0, pos_int} < (PMIN + stp)) pos_nxt = PMIN[POS_W-1:0];
      else pos_nxt = pos_int - stp[POS_W-1:0];
    end
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      prev     <= 2'b00;
      q        <= '0;
      pos_int  <= POS_W'(POS_INIT);
      paddle_y <= POS_W'(POS_INIT);
      step_cw  <= 1'b0;
      step_ccw <= 1'b0;
      quad_err <= 1'b0;
    end else begin
      prev     <= deb;
      q        <= q_d;
      pos_int  <= pos_nxt;
      step_cw  <= cw_c;
      step_ccw <= ccw_c;
      quad_err <= err_c;
      // Samples pre-step pos_int when a detent lands on the tick edge
      if (frame_tick) paddle_y <= pos_int;
    end
  end
endmodule
